// File: rtl/hex_stream_demux.sv
// -----------------------------------------------------------------------------
// hex_stream_demux
//
// Registered 1-to-2 stream demultiplexer. A single valid/ready producer stream
// of WIDTH-bit words is steered, word by word, to one of two output lanes
// according to in_sel. Each lane buffers up to two words in a small FIFO, so a
// stalled consumer only blocks words addressed to its own lane. Each lane also
// keeps a free-running 16-bit count of words delivered to its consumer.
//
// Handshake semantics (all three streams): a transfer happens on a rising edge
// where valid=1 and ready=1 in the cycle before that edge. A source holding
// valid must keep its word stable until accepted, except that the producer may
// re-steer a stalled word by changing in_sel. in_ready depends only on in_sel
// and registered state, never on out0_ready/out1_ready, so there is no
// ready-to-ready combinational path.
//
// Ports:
//   clk         in   clock, rising edge
//   rst_n       in   asynchronous reset, active low
//   in_data     in   producer word
//   in_sel      in   destination lane of in_data (0 -> lane 0, 1 -> lane 1)
//   in_valid    in   producer has a word
//   in_ready    out  selected lane has room (occupancy != 2)
//   out0_data   out  lane 0 head word
//   out0_valid  out  lane 0 non-empty
//   out0_ready  in   lane 0 consumer takes the head
//   out1_data   out  lane 1 head word
//   out1_valid  out  lane 1 non-empty
//   out1_ready  in   lane 1 consumer takes the head
//   count0      out  words delivered on lane 0, modulo 2^16
//   count1      out  words delivered on lane 1, modulo 2^16
// -----------------------------------------------------------------------------
module hex_stream_demux #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out0_data,
    output logic             out0_valid,
    input  logic             out0_ready,
    output logic [WIDTH-1:0] out1_data,
    output logic             out1_valid,
    input  logic             out1_ready,
    output logic [15:0]      count0,
    output logic [15:0]      count1
);

    localparam int LANES = 2;
    localparam int DEPTH = 2;

    // Per-lane state. Index [l] is the lane, [s] the storage slot.
    logic [WIDTH-1:0] mem_q   [LANES][DEPTH];
    logic [WIDTH-1:0] mem_d   [LANES][DEPTH];
    logic             wp_q    [LANES];
    logic             wp_d    [LANES];
    logic             rp_q    [LANES];
    logic             rp_d    [LANES];
    logic [1:0]       occ_q   [LANES];
    logic [1:0]       occ_d   [LANES];
    logic [15:0]      cnt_q   [LANES];
    logic [15:0]      cnt_d   [LANES];

    // Per-lane handshake terms.
    logic             full_l  [LANES];
    logic             push_l  [LANES];
    logic             pop_l   [LANES];
    logic             rdy_l   [LANES];

    always_comb begin
        rdy_l[0] = out0_ready;
        rdy_l[1] = out1_ready;
    end

    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            full_l[l] = (occ_q[l] == 2'd2);
        end
    end

    // A full lane refuses a push even when it is popping in the same cycle;
    // this keeps in_ready free of any dependence on the consumer readies.
    assign in_ready = in_sel ? ~full_l[1] : ~full_l[0];

    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            push_l[l] = in_valid & in_ready & (in_sel == 1'(l));
            pop_l[l]  = (occ_q[l] != 2'd0) & rdy_l[l];
        end
    end

    // Next-state for every lane.
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            for (int s = 0; s < DEPTH; s++) begin
                mem_d[l][s] = mem_q[l][s];
            end
            wp_d[l]  = wp_q[l];
            rp_d[l]  = rp_q[l];
            occ_d[l] = occ_q[l];
            cnt_d[l] = cnt_q[l];

            if (push_l[l]) begin
                mem_d[l][wp_q[l]] = in_data;
                wp_d[l]           = ~wp_q[l];
            end

            if (pop_l[l]) begin
                rp_d[l]  = ~rp_q[l];
                cnt_d[l] = cnt_q[l] + 16'd1;
            end

            // Push and pop together leave occupancy unchanged; the new word
            // lands behind the departing head.
            unique case ({push_l[l], pop_l[l]})
                2'b10:   occ_d[l] = occ_q[l] + 2'd1;
                2'b01:   occ_d[l] = occ_q[l] - 2'd1;
                default: occ_d[l] = occ_q[l];
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int l = 0; l < LANES; l++) begin
                for (int s = 0; s < DEPTH; s++) begin
                    mem_q[l][s] <= '0;
                end
                wp_q[l]  <= 1'b0;
                rp_q[l]  <= 1'b0;
                occ_q[l] <= 2'd0;
                cnt_q[l] <= 16'd0;
            end
        end else begin
            for (int l = 0; l < LANES; l++) begin
                for (int s = 0; s < DEPTH; s++) begin
                    mem_q[l][s] <= mem_d[l][s];
                end
                wp_q[l]  <= wp_d[l];
                rp_q[l]  <= rp_d[l];
                occ_q[l] <= occ_d[l];
                cnt_q[l] <= cnt_d[l];
            end
        end
    end

    // Outputs come straight from registers: no in->out combinational path.
    // While a lane is empty its data output shows whatever slot rp points at.
    assign out0_data  = mem_q[0][rp_q[0]];
    assign out1_data  = mem_q[1][rp_q[1]];
    assign out0_valid = (occ_q[0] != 2'd0);
    assign out1_valid = (occ_q[1] != 2'd0);
    assign count0     = cnt_q[0];
    assign count1     = cnt_q[1];

endmodule

// File: tb/tb_hex_stream_demux.sv
module tb_hex_stream_demux;

  localparam int WIDTH = 16;

  // ---------------------------------------------------------------- clock/reset
  logic             clk = 1'b0;
  logic             rst_n;
  logic [WIDTH-1:0] in_data;
  logic             in_sel;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out0_data;
  logic             out0_valid;
  logic             out0_ready;
  logic [WIDTH-1:0] out1_data;
  logic             out1_valid;
  logic             out1_ready;
  logic [15:0]      count0;
  logic [15:0]      count1;

  always #5 clk = ~clk;

  hex_stream_demux #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_data    (in_data),
    .in_sel     (in_sel),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out0_data  (out0_data),
    .out0_valid (out0_valid),
    .out0_ready (out0_ready),
    .out1_data  (out1_data),
    .out1_valid (out1_valid),
    .out1_ready (out1_ready),
    .count0     (count0),
    .count1     (count1)
  );

  // ---------------------------------------------------------------- scoreboard
  int               pass_cnt = 0;
  int               total_cnt = 0;
  logic [WIDTH-1:0] exp_q0[$];
  logic [WIDTH-1:0] exp_q1[$];
  logic [15:0]      mc0;
  logic [15:0]      mc1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Behavioural model: two FIFOs of capacity 2 plus delivered-word counters.
  // Acceptance is decided from occupancy before this cycle's pops.
  task automatic model_step();
    bit acc;
    acc = in_valid && ((in_sel ? exp_q1.size() : exp_q0.size()) != 2);
    if (out0_ready && exp_q0.size() > 0) begin
      void'(exp_q0.pop_front());
      mc0 = mc0 + 16'd1;
    end
    if (out1_ready && exp_q1.size() > 0) begin
      void'(exp_q1.pop_front());
      mc1 = mc1 + 16'd1;
    end
    if (acc) begin
      if (in_sel) exp_q1.push_back(in_data);
      else        exp_q0.push_back(in_data);
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, "_in_ready"}, in_ready,
          ((in_sel ? exp_q1.size() : exp_q0.size()) != 2));
    check({tag, "_v0"}, out0_valid, exp_q0.size() != 0);
    check({tag, "_v1"}, out1_valid, exp_q1.size() != 0);
    if (exp_q0.size() != 0) check({tag, "_d0"}, out0_data, exp_q0[0]);
    if (exp_q1.size() != 0) check({tag, "_d1"}, out1_data, exp_q1[0]);
    check({tag, "_count0"}, count0, mc0);
    check({tag, "_count1"}, count1, mc1);
  endtask

  // ---------------------------------------------------------------- drivers
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [WIDTH-1:0] d, input logic s);
    in_valid = v;
    in_data  = d;
    in_sel   = s;
  endtask

  // ---------------------------------------------------------------- vectors
  typedef struct {
    logic [WIDTH-1:0] data;
    logic             sel;
    logic [15:0]      exp_c0;
    logic [15:0]      exp_c1;
  } steer_vec_t;

  steer_vec_t vecs[5];

  initial begin
    int guard;

    vecs[0] = '{data: 16'h0001, sel: 1'b0, exp_c0: 16'd1, exp_c1: 16'd0};
    vecs[1] = '{data: 16'h0002, sel: 1'b1, exp_c0: 16'd1, exp_c1: 16'd1};
    vecs[2] = '{data: 16'h0003, sel: 1'b0, exp_c0: 16'd2, exp_c1: 16'd1};
    vecs[3] = '{data: 16'h00A5, sel: 1'b1, exp_c0: 16'd2, exp_c1: 16'd2};
    vecs[4] = '{data: 16'hFFFF, sel: 1'b0, exp_c0: 16'd3, exp_c1: 16'd2};

    rst_n      = 1'b0;
    drive(1'b0, '0, 1'b0);
    out0_ready = 1'b1;
    out1_ready = 1'b1;
    #1;
    check("rst_v0", out0_valid, 0);
    check("rst_v1", out1_valid, 0);
    check("rst_d0", out0_data, 0);
    check("rst_d1", out1_data, 0);
    check("rst_c0", count0, 0);
    check("rst_c1", count1, 0);
    check("rst_rdy_sel0", in_ready, 1);
    in_sel = 1'b1;
    #1;
    check("rst_rdy_sel1", in_ready, 1);
    step();
    step();
    rst_n = 1'b1;
    step();

    // ------------------------------------------------ steering table
    foreach (vecs[i]) begin
      drive(1'b1, vecs[i].data, vecs[i].sel);
      #1;
      check($sformatf("steer%0d_rdy", i), in_ready, 1);
      step();
      in_valid = 1'b0;
      #1;
      if (vecs[i].sel) begin
        check($sformatf("steer%0d_v1", i), out1_valid, 1);
        check($sformatf("steer%0d_d1", i), out1_data, vecs[i].data);
        check($sformatf("steer%0d_v0", i), out0_valid, 0);
      end else begin
        check($sformatf("steer%0d_v0", i), out0_valid, 1);
        check($sformatf("steer%0d_d0", i), out0_data, vecs[i].data);
        check($sformatf("steer%0d_v1", i), out1_valid, 0);
      end
      step();
      check($sformatf("steer%0d_c0", i), count0, vecs[i].exp_c0);
      check($sformatf("steer%0d_c1", i), count1, vecs[i].exp_c1);
      check($sformatf("steer%0d_empty0", i), out0_valid, 0);
      check($sformatf("steer%0d_empty1", i), out1_valid, 0);
    end

    // ------------------------------------------------ full lane / backpressure
    out1_ready = 1'b0;
    drive(1'b1, 16'hC001, 1'b1);
    step();
    drive(1'b1, 16'hC002, 1'b1);
    step();
    in_valid = 1'b0;
    #1;
    check("full_rdy_sel1", in_ready, 0);
    in_sel = 1'b0;
    #1;
    check("full_rdy_sel0", in_ready, 1);
    check("full_v1", out1_valid, 1);
    check("full_d1_head", out1_data, 16'hC001);
    drive(1'b1, 16'h00FF, 1'b0);
    step();
    in_valid = 1'b0;
    #1;
    check("full_lane0_v", out0_valid, 1);
    check("full_lane0_d", out0_data, 16'h00FF);
    step();
    check("full_lane0_drained", out0_valid, 0);
    out1_ready = 1'b1;
    in_sel     = 1'b1;
    #1;
    check("full_rdy_still0", in_ready, 0);
    step();
    check("full_d1_second", out1_data, 16'hC002);
    check("full_v1_second", out1_valid, 1);
    check("full_rdy_back", in_ready, 1);
    step();
    check("full_v1_done", out1_valid, 0);
    check("full_c0", count0, 16'd4);
    check("full_c1", count1, 16'd4);

    // ------------------------------------------------ push and pop at occ 1
    out0_ready = 1'b0;
    drive(1'b1, 16'h5555, 1'b0);
    step();
    in_valid = 1'b0;
    #1;
    check("pp_head", out0_data, 16'h5555);
    out0_ready = 1'b1;
    drive(1'b1, 16'h6666, 1'b0);
    #1;
    check("pp_rdy", in_ready, 1);
    step();
    in_valid   = 1'b0;
    out0_ready = 1'b0;
    #1;
    check("pp_v0", out0_valid, 1);
    check("pp_d0", out0_data, 16'h6666);
    check("pp_c0", count0, 16'd5);
    out0_ready = 1'b1;
    step();
    check("pp_single", out0_valid, 0);
    check("pp_c0_final", count0, 16'd6);

    // ------------------------------------------------ reset mid-stream
    out0_ready = 1'b0;
    drive(1'b1, 16'hAAAA, 1'b0);
    step();
    drive(1'b1, 16'hBBBB, 1'b0);
    step();
    in_valid = 1'b0;
    #1;
    check("mid_pre_d0", out0_data, 16'hAAAA);
    rst_n = 1'b0;
    #1;
    check("mid_v0", out0_valid, 0);
    check("mid_d0", out0_data, 0);
    check("mid_c0", count0, 0);
    check("mid_c1", count1, 0);
    check("mid_rdy", in_ready, 1);
    step();
    step();
    rst_n = 1'b1;
    drive(1'b1, 16'h1234, 1'b0);
    step();
    in_valid = 1'b0;
    #1;
    check("post_v0", out0_valid, 1);
    check("post_d0", out0_data, 16'h1234);
    check("post_c0", count0, 0);
    out0_ready = 1'b1;
    step();
    check("post_c0_pop", count0, 16'd1);
    check("post_empty", out0_valid, 0);

    // ------------------------------------------------ random soak
    mc0 = 16'd1;
    mc1 = 16'd0;
    exp_q0.delete();
    exp_q1.delete();
    for (int cyc = 0; cyc < 4000; cyc++) begin
      in_valid   = ($urandom_range(0, 9) < 7);
      in_sel     = 1'($urandom_range(0, 1));
      in_data    = WIDTH'($urandom);
      out0_ready = ($urandom_range(0, 9) < 6);
      out1_ready = ($urandom_range(0, 9) < 6);
      #1;
      check_model("soak");
      model_step();
      step();
    end

    // ------------------------------------------------ counter wrap on lane 1
    out0_ready = 1'b1;
    out1_ready = 1'b1;
    guard = 0;
    while (mc1 != 16'hFFFF && guard < 70000) begin
      drive(1'b1, WIDTH'($urandom), 1'b1);
      #1;
      model_step();
      step();
      guard++;
    end
    check("wrap_pre_c1", count1, 16'hFFFF);
    check("wrap_pre_c0", count0, mc0);
    in_valid = 1'b0;
    #1;
    check("wrap_v1", out1_valid, 1);
    model_step();
    step();
    check("wrap_c1", count1, 16'h0000);
    check_model("wrap_end");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
